tlb: RTL and testbench
======================

TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, which sets the number of entries; it SHALL be a power of two.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have search-port-0 request inputs s0_req / s0_vpn2 / s0_odd_page / s0_asid, widths 1/19/1/8.
REQ-005 SHALL have search-port-0 result outputs s0_found / s0_index / s0_pfn / s0_c / s0_d / s0_v, widths 1/4/20/3/1/1.
REQ-006 SHALL have search port 1 (s1_*) identical to port 0 and fully independent of it.
REQ-007 SHALL have write-port inputs we / w_index / w_vpn2 / w_asid / w_g, widths 1/4/19/8/1.
REQ-008 SHALL have write-port page inputs w_pfn0 / w_c0 / w_d0 / w_v0 and w_pfn1 / w_c1 / w_d1 / w_v1, widths 20/3/1/1 per page.
REQ-009 SHALL have read-port input r_index, 4 bits.
REQ-010 SHALL have read-port outputs r_vpn2 / r_asid / r_g / r_pfn0 / r_c0 / r_d0 / r_v0 / r_pfn1 / r_c1 / r_d1 / r_v1, with widths matching the write port.

Function
REQ-011 SHALL store, per entry: an entry-valid bit (e), vpn2, asid, g, and two page records {pfn, c, d, v}.
REQ-012 SHALL, when we=1 at a rising edge, load entry[w_index] from the write-port fields and set its e bit.
REQ-013 SHALL make a write visible to searches and reads from the following cycle onward.
REQ-014 SHALL return pre-write contents to any search or read sampled in the same cycle as a write.
REQ-015 SHALL treat an entry as matching a search when: e=1, and vpn2 equals the request vpn2, and (g=1 or asid equals the request asid).
REQ-016 SHALL register search results with 1-cycle latency: a request sampled with sN_req=1 at edge k produces results valid after edge k.
REQ-017 SHALL hold search outputs stable while sN_req=0.
REQ-018 SHALL, when several entries match, report the lowest-numbered matching index (priority encode).
REQ-019 SHALL select page record 1 when sN_odd_page=1 and page record 0 otherwise.
REQ-020 SHALL, on a miss, drive sN_found=0, and sN_index/pfn/c/d/v=0.
REQ-021 SHALL register read results with 1-cycle latency: r_index sampled at edge k produces entry contents after edge k.
REQ-022 SHALL always perform the read; there is no read-enable.
REQ-023 SHALL let both search ports, the read port and the write port operate in the same cycle without stalls.
REQ-024 SHALL ignore index bits above log2(TLBNUM).
REQ-025 SHALL have no back-pressure and no busy state: every request completes in exactly one cycle.

Reset
REQ-026 SHALL, while reset is asserted, clear every entry's e, g, v0 and v1 bits, and all search and read output registers, to 0.
REQ-027 SHALL NOT require entry data fields (vpn2, asid, pfn, c, d) to be reset.
REQ-028 SHALL drop a write coincident with reset assertion.
REQ-029 SHALL, after reset deasserts, report every search as a miss until the first write.

Structure
REQ-030 SHALL take TLBNUM, the field widths (VPN2_W=19, ASID_W=8, PFN_W=20, C_W=3) and the page-record typedef from shared package tlb_pkg.
REQ-031 SHALL use one sub-module, tlb_match_enc, instantiated once per search port, which takes the match vector and returns found and the lowest index.

Verification
REQ-032 SHALL cover: reset; then s0 search with vpn2=0, asid=0 -> s0_found=0 one cycle later.
REQ-033 SHALL cover: write idx 3 {vpn2=0x12345, asid=0x5A, g=0, pfn1=0xABCDE, v1=1}; search vpn2=0x12345, odd=1, asid=0x5A -> found=1, index=3, pfn=0xABCDE, v=1.
REQ-034 SHALL cover: the idx-3 entry searched with asid=0x5B -> found=0; rewrite it with g=1 -> the same search gives found=1.
REQ-035 SHALL cover: entries 5 and 9 holding an identical vpn2/asid; search -> index=5.
REQ-036 SHALL cover: a write to idx 7 and a search for its new vpn2 in the same cycle -> miss; the same search next cycle -> hit, index=7.
REQ-037 SHALL cover: read r_index=3 after the write -> all r_* fields equal the written values; assert reset mid-sequence -> all outputs 0 and the next search misses.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared widths and record types for the dual-search TLB.
package tlb_pkg;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned VPN2_W = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned C_W    = 3;
  localparam int unsigned IDX_W  = 4;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    page_t            pg;
  } srch_t;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    page_t             p0;
    page_t             p1;
  } entry_t;

endpackage

// File: rtl/tlb_match_enc.sv
// Priority encoder over a TLB match vector: lowest matching index wins.
module tlb_match_enc #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  match,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = |match;
    index = '0;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (match[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully associative TLB with two registered search ports, one read port and one write port.
module tlb #(
  parameter int unsigned TLBNUM = tlb_pkg::TLBNUM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s0_req,
  input  logic [tlb_pkg::VPN2_W-1:0] s0_vpn2,
  input  logic                       s0_odd_page,
  input  logic [tlb_pkg::ASID_W-1:0] s0_asid,
  output logic                       s0_found,
  output logic [tlb_pkg::IDX_W-1:0]  s0_index,
  output logic [tlb_pkg::PFN_W-1:0]  s0_pfn,
  output logic [tlb_pkg::C_W-1:0]    s0_c,
  output logic                       s0_d,
  output logic                       s0_v,
  input  logic                       s1_req,
  input  logic [tlb_pkg::VPN2_W-1:0] s1_vpn2,
  input  logic                       s1_odd_page,
  input  logic [tlb_pkg::ASID_W-1:0] s1_asid,
  output logic                       s1_found,
  output logic [tlb_pkg::IDX_W-1:0]  s1_index,
  output logic [tlb_pkg::PFN_W-1:0]  s1_pfn,
  output logic [tlb_pkg::C_W-1:0]    s1_c,
  output logic                       s1_d,
  output logic                       s1_v,
  input  logic                       we,
  input  logic [tlb_pkg::IDX_W-1:0]  w_index,
  input  logic [tlb_pkg::VPN2_W-1:0] w_vpn2,
  input  logic [tlb_pkg::ASID_W-1:0] w_asid,
  input  logic                       w_g,
  input  logic [tlb_pkg::PFN_W-1:0]  w_pfn0,
  input  logic [tlb_pkg::C_W-1:0]    w_c0,
  input  logic                       w_d0,
  input  logic                       w_v0,
  input  logic [tlb_pkg::PFN_W-1:0]  w_pfn1,
  input  logic [tlb_pkg::C_W-1:0]    w_c1,
  input  logic                       w_d1,
  input  logic                       w_v1,
  input  logic [tlb_pkg::IDX_W-1:0]  r_index,
  output logic [tlb_pkg::VPN2_W-1:0] r_vpn2,
  output logic [tlb_pkg::ASID_W-1:0] r_asid,
  output logic                       r_g,
  output logic [tlb_pkg::PFN_W-1:0]  r_pfn0,
  output logic [tlb_pkg::C_W-1:0]    r_c0,
  output logic                       r_d0,
  output logic                       r_v0,
  output logic [tlb_pkg::PFN_W-1:0]  r_pfn1,
  output logic [tlb_pkg::C_W-1:0]    r_c1,
  output logic                       r_d1,
  output logic                       r_v1
);

  import tlb_pkg::*;

  localparam int unsigned IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

  logic [TLBNUM-1:0] e_q, g_q, v0_q, v1_q;
  logic [VPN2_W-1:0] vpn2_q [TLBNUM];
  logic [ASID_W-1:0] asid_q [TLBNUM];
  logic [PFN_W-1:0]  pfn0_q [TLBNUM];
  logic [PFN_W-1:0]  pfn1_q [TLBNUM];
  logic [C_W-1:0]    c0_q   [TLBNUM];
  logic [C_W-1:0]    c1_q   [TLBNUM];
  logic [TLBNUM-1:0] d0_q, d1_q;

  logic [IW-1:0] w_idx, r_idx;
  assign w_idx = w_index[IW-1:0];
  assign r_idx = r_index[IW-1:0];

  // Only the flags are reset; data fields simply hold while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q  <= '0;
      g_q  <= '0;
      v0_q <= '0;
      v1_q <= '0;
    end else if (we) begin
      e_q[w_idx]    <= 1'b1;
      g_q[w_idx]    <= w_g;
      v0_q[w_idx]   <= w_v0;
      v1_q[w_idx]   <= w_v1;
      vpn2_q[w_idx] <= w_vpn2;
      asid_q[w_idx] <= w_asid;
      pfn0_q[w_idx] <= w_pfn0;
      pfn1_q[w_idx] <= w_pfn1;
      c0_q[w_idx]   <= w_c0;
      c1_q[w_idx]   <= w_c1;
      d0_q[w_idx]   <= w_d0;
      d1_q[w_idx]   <= w_d1;
    end
  end

  logic              s_req  [2];
  logic [VPN2_W-1:0] s_vpn2 [2];
  logic              s_odd  [2];
  logic [ASID_W-1:0] s_asid [2];
  srch_t             s_res  [2];

  assign s_req[0]  = s0_req;
  assign s_vpn2[0] = s0_vpn2;
  assign s_odd[0]  = s0_odd_page;
  assign s_asid[0] = s0_asid;
  assign s_req[1]  = s1_req;
  assign s_vpn2[1] = s1_vpn2;
  assign s_odd[1]  = s1_odd_page;
  assign s_asid[1] = s1_asid;

  for (genvar p = 0; p < 2; p++) begin : g_srch
    logic [TLBNUM-1:0] match;
    logic              hit;
    logic [IW-1:0]     hit_idx;
    srch_t             res_d, res_q;

    always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
        match[i] = e_q[i] && (vpn2_q[i] == s_vpn2[p]) && (g_q[i] || (asid_q[i] == s_asid[p]));
      end
    end

    tlb_match_enc #(
      .N  (TLBNUM),
      .IW (IW)
    ) u_enc (
      .match (match),
      .found (hit),
      .index (hit_idx)
    );

    always_comb begin
      res_d = '0;
      if (hit) begin
        res_d.found = 1'b1;
        res_d.index = IDX_W'(hit_idx);
        res_d.pg    = s_odd[p] ? {pfn1_q[hit_idx], c1_q[hit_idx], d1_q[hit_idx], v1_q[hit_idx]}
                               : {pfn0_q[hit_idx], c0_q[hit_idx], d0_q[hit_idx], v0_q[hit_idx]};
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)         res_q <= '0;
      else if (s_req[p]) res_q <= res_d;
    end

    assign s_res[p] = res_q;
  end

  assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} = s_res[0];
  assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} = s_res[1];

  entry_t r_d, r_q;

  always_comb begin
    r_d.vpn2 = vpn2_q[r_idx];
    r_d.asid = asid_q[r_idx];
    r_d.g    = g_q[r_idx];
    r_d.p0   = {pfn0_q[r_idx], c0_q[r_idx], d0_q[r_idx], v0_q[r_idx]};
    r_d.p1   = {pfn1_q[r_idx], c1_q[r_idx], d1_q[r_idx], v1_q[r_idx]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} = r_q;

endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: driver pushes model predictions, monitor pops and compares.
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req, s0_odd_page, s1_req, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s0_d, s0_v, s1_found, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0]  w_asid, r_asid;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  w_c0, w_c1, r_c0, r_c1;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;

  always #5 clk = ~clk;

  tlb #(.TLBNUM(16)) u_dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d),
    .s0_v(s0_v),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d),
    .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
  );

  typedef struct packed {
    logic [18:0] vpn2; logic [7:0] asid; logic g;
    logic [19:0] pfn0; logic [2:0] c0; logic d0; logic v0;
    logic [19:0] pfn1; logic [2:0] c1; logic d1; logic v1;
  } rd_t;

  typedef struct packed {
    logic found; logic [3:0] index; logic [19:0] pfn; logic [2:0] c; logic d; logic v;
  } sr_t;

  // Reference TLB: one record per entry, e marks a written entry.
  typedef struct packed { logic e; rd_t f; } ment_t;
  ment_t m [16];
  bit    known [16];

  sr_t  q0 [$];
  sr_t  q1 [$];
  rd_t  qr [$];
  bit   qrc [$];
  sr_t  last0, last1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic sr_t model_search(input logic [18:0] vpn2, input logic odd,
                                       input logic [7:0] asid);
    sr_t r = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i].e && m[i].f.vpn2 == vpn2 && (m[i].f.g || m[i].f.asid == asid)) begin
        r.found = 1'b1;
        r.index = i[3:0];
        if (odd) {r.pfn, r.c, r.d, r.v} = {m[i].f.pfn1, m[i].f.c1, m[i].f.d1, m[i].f.v1};
        else     {r.pfn, r.c, r.d, r.v} = {m[i].f.pfn0, m[i].f.c0, m[i].f.d0, m[i].f.v0};
        return r;
      end
    end
    return r;
  endfunction

  // Predict this cycle's responses from pre-write state, then apply the write.
  task automatic step();
    if (s0_req) last0 = model_search(s0_vpn2, s0_odd_page, s0_asid);
    if (s1_req) last1 = model_search(s1_vpn2, s1_odd_page, s1_asid);
    q0.push_back(last0);
    q1.push_back(last1);
    qr.push_back(m[r_index].f);
    qrc.push_back(known[r_index]);
    if (we) begin
      m[w_index].e = 1'b1;
      m[w_index].f = '{w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                       w_pfn1, w_c1, w_d1, w_v1};
      known[w_index] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic v0,
                    input logic [19:0] pfn1, input logic v1);
    we = 1'b1; w_index = idx[3:0]; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = 3'd2; w_d0 = 1'b0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = 3'd5; w_d1 = 1'b1; w_v1 = v1;
  endtask

  task automatic srch(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s0_req = 1'b1; s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    s1_req = 1'b1; s1_vpn2 = vpn2; s1_odd_page = ~odd; s1_asid = asid;
  endtask

  task automatic idle();
    we = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
  endtask

  // Called at a negedge with the scoreboard drained; a write is held across the reset edge.
  task automatic do_reset();
    reset = 1'b1;
    we = 1'b1; w_index = 4'd2; w_vpn2 = 19'h00777; w_asid = 8'h22; w_g = 1'b1;
    w_v0 = 1'b1; w_v1 = 1'b1;
    #1;
    chk("reset_outputs_zero",
        128'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
              s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
              r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}),
        128'd0);
    for (int i = 0; i < 16; i++) begin
      m[i].e = 1'b0; m[i].f.g = 1'b0; m[i].f.v0 = 1'b0; m[i].f.v1 = 1'b0;
    end
    last0 = '0;
    last1 = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
  endtask

  initial begin : monitor
    sr_t e0, e1;
    rd_t er;
    bit  ec;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("s0_result", 128'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}), 128'(e0));
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("s1_result", 128'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}), 128'(e1));
      end
      if (qr.size() > 0) begin
        er = qr.pop_front();
        ec = qrc.pop_front();
        if (ec)
          chk("read_result", 128'({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                                   r_pfn1, r_c1, r_d1, r_v1}), 128'(er));
      end
    end
  end

  localparam logic [18:0] VPOOL [4] = '{19'h12345, 19'h00777, 19'h55555, 19'h7ffff};

  initial begin : driver
    for (int i = 0; i < 16; i++) begin
      m[i] = '0;
      known[i] = 1'b0;
    end
    last0 = '0; last1 = '0;
    reset = 1'b1;
    idle();
    s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    r_index = 4'd3;
    @(negedge clk);
    do_reset();

    srch(19'h0, 1'b0, 8'h00); step();
    idle(); wr(3, 19'h12345, 8'h5a, 1'b0, 20'h11111, 1'b0, 20'habcde, 1'b1); step();
    idle(); srch(19'h12345, 1'b1, 8'h5a); step();
    srch(19'h12345, 1'b1, 8'h5b); step();
    idle(); wr(3, 19'h12345, 8'h5a, 1'b1, 20'h11111, 1'b1, 20'habcde, 1'b1); step();
    idle(); srch(19'h12345, 1'b1, 8'h5b); step();
    idle(); s0_vpn2 = 19'h0; step();
    wr(5, 19'h00777, 8'h22, 1'b0, 20'h55555, 1'b1, 20'h55556, 1'b1); step();
    wr(9, 19'h00777, 8'h22, 1'b0, 20'h99999, 1'b1, 20'h9999a, 1'b0); step();
    idle(); srch(19'h00777, 1'b0, 8'h22); step();
    idle(); wr(7, 19'h55555, 8'h01, 1'b0, 20'h77777, 1'b1, 20'h77778, 1'b1);
    srch(19'h55555, 1'b0, 8'h01); step();
    idle(); srch(19'h55555, 1'b0, 8'h01); step();
    idle(); r_index = 4'd7; step();
    r_index = 4'd3; step();
    do_reset();
    srch(19'h55555, 1'b0, 8'h01); step();
    srch(19'h00777, 1'b1, 8'h22); step();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        continue;
      end
      we = ($urandom_range(0, 1) == 1);
      w_index = 4'($urandom_range(0, 15));
      w_vpn2 = VPOOL[$urandom_range(0, 3)];
      w_asid = ($urandom_range(0, 1) == 1) ? 8'h5a : 8'h22;
      w_g = ($urandom_range(0, 3) == 0);
      w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
      w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
      s0_req = ($urandom_range(0, 3) != 0);
      s0_vpn2 = VPOOL[$urandom_range(0, 3)];
      s0_odd_page = 1'($urandom);
      s0_asid = ($urandom_range(0, 1) == 1) ? 8'h5a : 8'h22;
      s1_req = ($urandom_range(0, 3) != 0);
      s1_vpn2 = VPOOL[$urandom_range(0, 3)];
      s1_odd_page = 1'($urandom);
      s1_asid = ($urandom_range(0, 1) == 1) ? 8'h5a : 8'h22;
      r_index = 4'($urandom_range(0, 15));
      step();
    end

    idle();
    step();
    chk("scoreboard_drained", 128'(q0.size() + q1.size() + qr.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
